// File: rtl/ir_dsdm_rx.sv
// ir_dsdm_rx: IR receive demodulator; detects carrier from sdi edges per ock period
// and samples it once per uck unit into a frame delivered with a one-clk ack.
module ir_dsdm_rx #(
  parameter int FRAME_W  = 160,
  parameter int END_IDLE = 32,
  parameter int SYNC_N   = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               req,
  input  logic               req_clear,
  input  logic               sdi,
  input  logic               ock,
  input  logic               uck,
  input  logic [31:0]        dsdm_dout_ir_rx_carrier_off,
  output logic               ack,
  output logic [FRAME_W-1:0] frame
);
  localparam int CW = $clog2(FRAME_W + 1);
  localparam int IW = $clog2(END_IDLE + 1);
  typedef enum logic [1:0] {IDLE, ARMED, RX, DONE} state_t;
  state_t             state, state_n;
  logic [SYNC_N:0]    sdi_s, ock_s, uck_s;
  logic               sdi_rise, ock_rise, uck_fall;
  logic               sdi_seen, carrier_on, req_q;
  logic [31:0]        gap, dout;
  logic [FRAME_W-1:0] shreg, shreg_n, frame_n, sh;
  logic [CW-1:0]      count, count_n, cnt_inc;
  logic [IW-1:0]      idle, idle_n, idl_inc;
  // Top bit of each chain is the previous synchronized value, used for edge detection.
  assign sdi_rise = sdi_s[SYNC_N-1] & ~sdi_s[SYNC_N];
  assign ock_rise = ock_s[SYNC_N-1] & ~ock_s[SYNC_N];
  assign uck_fall = ~uck_s[SYNC_N-1] & uck_s[SYNC_N];
  // gap above 7FFFFFFF would make the subtraction wrap; clamp dout at zero instead.
  assign dout = gap[31] ? '0 : 32'h7FFF_FFFF - gap;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdi_s      <= '0;
      ock_s      <= '0;
      uck_s      <= '0;
      gap        <= '0;
      sdi_seen   <= 1'b0;
      carrier_on <= 1'b0;
    end else begin
      sdi_s      <= {sdi_s[SYNC_N-1:0], sdi};
      ock_s      <= {ock_s[SYNC_N-1:0], ock};
      uck_s      <= {uck_s[SYNC_N-1:0], uck};
      carrier_on <= dout >= dsdm_dout_ir_rx_carrier_off;
      if (ock_rise) begin
        gap      <= (sdi_seen | sdi_rise) ? '0 : (&gap ? gap : gap + 32'd1);
        sdi_seen <= 1'b0;
      end else if (sdi_rise) begin
        sdi_seen <= 1'b1;
      end
    end
  end
  assign sh      = {shreg[FRAME_W-2:0], carrier_on};
  assign cnt_inc = count + CW'(1);
  assign idl_inc = carrier_on ? '0 : idle + IW'(1);
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = count;
    idle_n  = idle;
    frame_n = frame;
    case (state)
      IDLE:  state_n = (req & ~req_q) ? ARMED : IDLE;
      ARMED: if (carrier_on) begin
        state_n = RX;
        shreg_n = '0;
        count_n = '0;
        idle_n  = '0;
      end
      RX: if (uck_fall) begin
        shreg_n = sh;
        count_n = cnt_inc;
        idle_n  = idl_inc;
        if (idl_inc == IW'(END_IDLE)) begin
          state_n = DONE;
          frame_n = sh >> END_IDLE;
        end else if (cnt_inc == CW'(FRAME_W)) begin
          state_n = DONE;
          frame_n = sh;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      frame_n = frame;
    end
    if (req_clear) begin
      state_n = IDLE;
      frame_n = '0;
      shreg_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      req_q <= 1'b0;
      shreg <= '0;
      count <= '0;
      idle  <= '0;
      frame <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= req;
      shreg <= shreg_n;
      count <= count_n;
      idle  <= idle_n;
      frame <= frame_n;
      ack   <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_ir_dsdm_rx.sv
// tb_ir_dsdm_rx: directed bench driving synthetic carrier/unit waveforms into ir_dsdm_rx
// and checking acks and received frames against hand-computed patterns.
module tb_ir_dsdm_rx;
  logic         clk = 0, rstn = 0, enable = 0, req = 0, req_clear = 0;
  logic         sdi = 0, ock = 0, uck = 0;
  logic [31:0]  thr = 32'h7FFF_FFFD;
  logic         ack;
  logic [159:0] frame;
  int           checks = 0, failures = 0, acks = 0;

  ir_dsdm_rx dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .req_clear(req_clear),
    .sdi(sdi), .ock(ock), .uck(uck), .dsdm_dout_ir_rx_carrier_off(thr),
    .ack(ack), .frame(frame)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ack) acks++;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ock period: optional sdi pulse, then an ock rising edge.
  task automatic ock_period(input bit pulse);
    sdi = pulse; tick(3);
    sdi = 0;     tick(3);
    ock = 1;     tick(3);
    ock = 0;     tick(3);
  endtask

  // One protocol unit: four ock periods, uck falls at the end.
  task automatic unit(input bit on, input bit miss_last);
    for (int i = 0; i < 4; i++) begin
      ock_period(on && !(miss_last && i == 3));
      if (i == 0) uck = 1;
    end
    uck = 0;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) unit(bits[i], 1'b0);
  endtask

  task automatic idle_units(input int n);
    repeat (n) unit(1'b0, 1'b0);
  endtask

  task automatic arm();
    enable = 1;
    repeat (4) ock_period(1'b0);
    req = 1; tick(2);
    req = 0; tick(2);
  endtask

  initial begin
    tick(5);
    check("rst_ack", ack, 0);
    check("rst_frame", frame, 0);
    rstn = 1;
    tick(100);
    check("idle_no_ack", acks, 0);
    check("idle_frame", frame, 0);
    // Plain frame, trailing idle stripped
    arm(); send(32'hB4D2C5, 24); idle_units(32); tick(10);
    check("p1_ack", acks, 1);
    check("p1_frame", frame, 160'hB4D2C5);
    // NEC-like: 16 ones, 8 zeros, no early end
    arm(); send(32'hFFFF00A5, 32); tick(10);
    check("nec_no_early", acks, 1);
    idle_units(32); tick(10);
    check("nec_ack", acks, 2);
    check("nec_frame", frame, 160'hFFFF00A5);
    // Strict threshold: a missing last pulse turns a unit off
    thr = 32'h7FFF_FFFF;
    arm(); unit(1, 0); unit(1, 1); unit(1, 0); idle_units(32); tick(10);
    check("miss_ack", acks, 3);
    check("miss_frame", frame, 160'b101);
    thr = 32'h7FFF_FFFD;
    // req_clear mid-RX
    arm(); send(32'hFF, 8);
    check("clr_pre", acks, 3);
    req_clear = 1; tick(1); req_clear = 0; tick(2);
    check("clr_frame", frame, 0);
    idle_units(32); tick(10);
    check("clr_no_ack", acks, 3);
    arm(); send(32'hA5C3, 16); idle_units(32); tick(10);
    check("after_clr_ack", acks, 4);
    check("after_clr_frame", frame, 160'hA5C3);
    // enable drop mid-RX holds frame
    arm(); send(32'hFF, 8);
    enable = 0; tick(2); enable = 1;
    idle_units(32); tick(10);
    check("en_no_ack", acks, 4);
    check("en_frame_held", frame, 160'hA5C3);
    // Continuous carrier fills the frame; req during RX is ignored
    arm();
    for (int i = 0; i < 159; i++) begin
      unit(1, 0);
      if (i == 80) begin req = 1; tick(2); req = 0; end
    end
    tick(10);
    check("full_159", acks, 4);
    unit(1, 0); tick(10);
    check("full_ack", acks, 5);
    check("full_frame", frame, {160{1'b1}});
    idle_units(4); tick(10);
    check("full_single_ack", acks, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
